// File: rtl/tl_master.sv
// +----------------------------------------------------------------------------+
// | Module      : tl_master                                                    |
// | Description : Single-outstanding TileLink-UL style master with a 2-entry   |
// |               request FIFO, A/D channel handshake and response timeout.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tl_master #(
  parameter int A_CHANNEL_SIZE = 53,
  parameter int D_CHANNEL_SIZE = 43,
  parameter int TIMEOUT        = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [9:0]                req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      req_ready,
  output logic [A_CHANNEL_SIZE-1:0] a_channel,
  output logic                      a_valid,
  output logic                      a_ready,
  input  logic                      backpressureslave,
  input  logic [D_CHANNEL_SIZE-1:0] d_channel,
  input  logic                      d_valid,
  output logic                      d_ready,
  input  logic                      d_error,
  output logic                      rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam int         FIFO_W      = 43;
  localparam logic [2:0] OP_PUT      = 3'd0;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACKDATA  = 3'd1;
  localparam logic [2:0] A_SIZE      = 3'd5;
  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);

  state_t                    state_q, state_d;
  logic [FIFO_W-1:0]         fifo_mem_q [2];
  logic [1:0]                fifo_cnt_q, fifo_cnt_d;
  logic                      fifo_rd_q, fifo_wr_q;
  logic [A_CHANNEL_SIZE-1:0] a_q, a_d;
  logic                      wr_q, wr_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [31:0]               rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic                      push, pop;
  logic [FIFO_W-1:0]         head;
  logic [2:0]                exp_op;
  logic                      unused_d;

  assign head      = fifo_mem_q[fifo_rd_q];
  assign exp_op    = wr_q ? OP_ACK : OP_ACKDATA;
  assign unused_d  = ^d_channel[39:34];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign req_ready = (fifo_cnt_q != 2'd2) || pop;
  assign push      = req_valid && req_ready;

  assign a_channel = a_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    unique case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 2'd1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 2'd1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_cnt_q <= 2'd0;
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
    end else begin
      fifo_cnt_q <= fifo_cnt_d;
      if (push) fifo_wr_q <= ~fifo_wr_q;
      if (pop)  fifo_rd_q <= ~fifo_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[fifo_wr_q] <= {req_write, req_addr, req_wdata};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    pop       = 1'b0;
    a_valid   = 1'b0;
    a_ready   = 1'b0;
    d_ready   = 1'b0;
    rsp_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fifo_cnt_q != 2'd0) begin
          pop     = 1'b1;
          wr_d    = head[42];
          a_d     = A_CHANNEL_SIZE'({head[42] ? OP_PUT : OP_GET, 3'd0, A_SIZE, 2'd0,
                                      head[41:32], head[42] ? head[31:0] : 32'd0});
          cnt_d   = 8'd0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE, ST_WAIT: begin
        a_valid = 1'b1;
        a_ready = 1'b1;
        d_ready = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        // A D beat wins over a timeout landing in the same cycle.
        if (d_valid) begin
          rdata_d = wr_q ? 32'd0 : d_channel[31:0];
          err_d   = d_error || (d_channel[42:40] != exp_op) || (d_channel[33:32] != 2'd0);
          state_d = ST_RESP;
        end else if ((cnt_q + 8'd1) >= TIMEOUT_LIM) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else if ((state_q == ST_ISSUE) && backpressureslave) begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tl_master.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_tl_master                                                 |
// | Description : Directed self-checking bench for tl_master.                  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_tl_master;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic [52:0] a_channel;
  logic        a_valid, a_ready;
  logic        backpressureslave = 1'b0;
  logic [42:0] d_channel = '0;
  logic        d_valid = 1'b0;
  logic        d_ready;
  logic        d_error = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rsp_cnt = 0;

  tl_master #(.A_CHANNEL_SIZE(53), .D_CHANNEL_SIZE(43), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .a_channel(a_channel), .a_valid(a_valid), .a_ready(a_ready),
    .backpressureslave(backpressureslave),
    .d_channel(d_channel), .d_valid(d_valid), .d_ready(d_ready), .d_error(d_error),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!reset && rsp_valid) rsp_cnt <= rsp_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit wr, input logic [9:0] addr, input logic [31:0] data, output int t0);
    t0 = cyc;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
    for (int i = 0; i < 200 && !req_ready; i++) tick;
    if (!req_ready) chk("req_ready_timeout", 64'd0, 64'd1);
    tick;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic e, output int at);
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin
      tick;
      n++;
    end
    if (!rsp_valid) chk("rsp_timeout", 64'd0, 64'd1);
    d = rsp_rdata; e = rsp_error; at = cyc;
  endtask

  task automatic slave_reply(input int dly, input bit bp, input logic [2:0] op,
                             input logic [1:0] src, input bit err, input logic [31:0] data,
                             input logic [52:0] exp_a, input string tag);
    int n;
    n = 0;
    while (!a_valid && n < 100) begin
      tick;
      n++;
    end
    chk({tag, "_avalid"}, {63'd0, a_valid}, 64'd1);
    chk({tag, "_achan"}, {11'd0, a_channel}, {11'd0, exp_a});
    chk({tag, "_ready"}, {62'd0, a_ready, d_ready}, 64'd3);
    backpressureslave = bp;
    for (int i = 0; i < dly; i++) begin
      tick;
      chk({tag, "_hold_valid"}, {63'd0, a_valid}, 64'd1);
      chk({tag, "_hold_achan"}, {11'd0, a_channel}, {11'd0, exp_a});
    end
    d_channel = {op, 3'd0, 3'd5, src, data};
    d_error = err;
    d_valid = 1'b1;
    tick;
    d_valid = 1'b0; d_error = 1'b0; backpressureslave = 1'b0; d_channel = '0;
    chk({tag, "_drop"}, {61'd0, a_valid, a_ready, d_ready}, 64'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          t0, t1, t2, at, ti, base;

    // Reset state, observed before any clock edge
    #2 reset = 1'b1;
    #2;
    chk("rst_outs", {59'd0, a_valid, a_ready, d_ready, rsp_valid, rsp_error}, 64'd0);
    chk("rst_achan", {11'd0, a_channel}, 64'd0);
    chk("rst_rdata", {32'd0, rsp_rdata}, 64'd0);
    tick; tick;
    reset = 1'b0;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);

    // Put then Get, minimum latency
    send(1'b1, 10'h005, 32'hDEADBEEF, t0);
    slave_reply(0, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0, 53'h5005_DEAD_BEEF, "put5");
    wait_rsp(d, e, at);
    chk("put5_rsp", {31'd0, e, d}, 64'd0);
    chk("put5_latency", at - t0, 64'd3);
    tick;
    chk("put5_single", {63'd0, rsp_valid}, 64'd0);
    send(1'b0, 10'h005, 32'h0, t0);
    slave_reply(0, 1'b0, 3'd1, 2'd0, 1'b0, 32'hDEADBEEF, 53'h10_5005_0000_0000, "get5");
    wait_rsp(d, e, at);
    chk("get5_rsp", {31'd0, e, d}, {32'd0, 32'hDEADBEEF});
    tick;

    // Three back-to-back requests fill the FIFO behind the outstanding one
    backpressureslave = 1'b1;
    send(1'b0, 10'h001, 32'h0, t0);
    send(1'b1, 10'h002, 32'hCAFE0002, t1);
    send(1'b0, 10'h3FF, 32'h0, t2);
    chk("b2b_full", {63'd0, req_ready}, 64'd0);
    tick;
    chk("b2b_full_hold", {63'd0, req_ready}, 64'd0);
    slave_reply(0, 1'b1, 3'd1, 2'd0, 1'b0, 32'h11111111, 53'h10_5001_0000_0000, "b2b1");
    wait_rsp(d, e, at);
    chk("b2b1_rsp", {31'd0, e, d}, {32'd0, 32'h11111111});
    chk("b2b_resp_full", {63'd0, req_ready}, 64'd0);
    tick;
    chk("b2b_pop_ready", {63'd0, req_ready}, 64'd1);
    slave_reply(1, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0, 53'h5002_CAFE_0002, "b2b2");
    wait_rsp(d, e, at);
    chk("b2b2_rsp", {31'd0, e, d}, 64'd0);
    slave_reply(0, 1'b0, 3'd1, 2'd0, 1'b0, 32'h33333333, 53'h10_53FF_0000_0000, "b2b3");
    wait_rsp(d, e, at);
    chk("b2b3_rsp", {31'd0, e, d}, {32'd0, 32'h33333333});
    tick;

    // Timeout with no D beat, then stray d_valid in IDLE is ignored
    send(1'b0, 10'h020, 32'h0, t0);
    for (int i = 0; i < 10 && !a_valid; i++) tick;
    ti = cyc;
    chk("to_achan", {11'd0, a_channel}, {11'd0, 53'h10_5020_0000_0000});
    wait_rsp(d, e, at);
    chk("to_cycles", at - ti, 64'd64);
    chk("to_rsp", {31'd0, e, d}, {31'd0, 1'b1, 32'd0});
    chk("to_avalid", {63'd0, a_valid}, 64'd0);
    tick;
    chk("to_idle", {62'd0, a_valid, d_ready}, 64'd0);
    base = rsp_cnt;
    d_channel = {3'd1, 3'd0, 3'd5, 2'd0, 32'h77777777};
    d_valid = 1'b1;
    tick; tick;
    d_valid = 1'b0; d_channel = '0;
    tick; tick;
    chk("idle_dvalid_ignored", rsp_cnt - base, 64'd0);
    chk("idle_dvalid_avalid", {63'd0, a_valid}, 64'd0);

    // Slow slave with backpressure: a_channel stable, one pulse
    base = rsp_cnt;
    send(1'b0, 10'h0AA, 32'h0, t0);
    slave_reply(4, 1'b1, 3'd1, 2'd0, 1'b0, 32'hA5A55A5A, 53'h10_50AA_0000_0000, "slow");
    wait_rsp(d, e, at);
    chk("slow_rsp", {31'd0, e, d}, {32'd0, 32'hA5A55A5A});
    tick; tick;
    chk("slow_one_pulse", rsp_cnt - base, 64'd1);

    // Error responses
    send(1'b0, 10'h010, 32'h0, t0);
    slave_reply(0, 1'b0, 3'd0, 2'd0, 1'b0, 32'h0, 53'h10_5010_0000_0000, "err_op");
    wait_rsp(d, e, at);
    chk("err_op_rsp", {63'd0, e}, 64'd1);
    send(1'b0, 10'h012, 32'h0, t0);
    slave_reply(0, 1'b0, 3'd1, 2'd1, 1'b0, 32'h0, 53'h10_5012_0000_0000, "err_src");
    wait_rsp(d, e, at);
    chk("err_src_rsp", {63'd0, e}, 64'd1);
    send(1'b1, 10'h013, 32'h0, t0);
    slave_reply(0, 1'b0, 3'd1, 2'd0, 1'b0, 32'h0, 53'h5013_0000_0000, "err_putop");
    wait_rsp(d, e, at);
    chk("err_putop_rsp", {31'd0, e, d}, {31'd0, 1'b1, 32'd0});
    send(1'b0, 10'h011, 32'h0, t0);
    slave_reply(0, 1'b0, 3'd1, 2'd0, 1'b1, 32'h12345678, 53'h10_5011_0000_0000, "err_derr");
    wait_rsp(d, e, at);
    chk("err_derr_rsp", {31'd0, e, d}, {31'd0, 1'b1, 32'h12345678});
    tick;

    // Reset while waiting on the slave abandons the transaction
    base = rsp_cnt;
    send(1'b0, 10'h040, 32'h0, t0);
    for (int i = 0; i < 10 && !a_valid; i++) tick;
    backpressureslave = 1'b1;
    tick; tick;
    chk("rstw_pre", {63'd0, a_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstw_outs", {59'd0, a_valid, a_ready, d_ready, rsp_valid, rsp_error}, 64'd0);
    chk("rstw_achan", {11'd0, a_channel}, 64'd0);
    chk("rstw_rdata", {32'd0, rsp_rdata}, 64'd0);
    backpressureslave = 1'b0;
    tick;
    reset = 1'b0;
    d_channel = {3'd1, 3'd0, 3'd5, 2'd0, 32'h99999999};
    d_valid = 1'b1;
    tick;
    d_valid = 1'b0; d_channel = '0;
    for (int i = 0; i < 5; i++) tick;
    chk("rstw_no_rsp", rsp_cnt - base, 64'd0);
    chk("rstw_idle", {62'd0, a_valid, req_ready}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tl_master.md
TL_MASTER -- requirements
Module: tl_master

Interface
REQ-001 SHALL have parameter A_CHANNEL_SIZE, default 53, A-channel bus width.
REQ-002 SHALL have parameter D_CHANNEL_SIZE, default 43, D-channel bus width.
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum cycles from A issue to D beat before abort.
REQ-004 SHALL have ports:
- clk  input  1  sole clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high.
- req_valid  input  1  processor request present.
- req_write  input  1  1 = PutFullData, 0 = Get.
- req_addr  input  10  word address.
- req_wdata  input  32  write data.
- req_ready  output  1  request FIFO not full.
- a_channel  output  A_CHANNEL_SIZE  {opcode[52:50], param[49:47], size[46:44], source[43:42], address[41:32], data[31:0]}.
- a_valid  output  1  A beat valid.
- a_ready  output  1  A fields stable for slave sampling.
- backpressureslave  input  1  slave busy with current beat.
- d_channel  input  D_CHANNEL_SIZE  {opcode[42:40], param[39:37], size[36:34], source[33:32], data[31:0]}.
- d_valid  input  1  D beat valid.
- d_ready  output  1  master accepts D beat.
- d_error  input  1  slave error flag.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  Get read data.
- rsp_error  output  1  response is an error.

Function
REQ-005 SHALL buffer requests in a 2-entry FIFO; req_ready = FIFO not full; push when req_valid && req_ready.
REQ-006 SHALL support simultaneous push and pop on a full FIFO only if pop occurs that cycle; otherwise req_ready=0 blocks the push.
REQ-007 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-008 IDLE: FIFO non-empty -> pop head into the A register, go to ISSUE next cycle; empty -> stay.
REQ-009 A register encoding SHALL be opcode 0 for write and 4 for read, param 0, size 5, source 0, address = req_addr, data = req_wdata (0 for Get).
REQ-010 ISSUE: a_valid=1, a_ready=1, d_ready=1; on backpressureslave=1 or d_valid=1 -> WAIT (if d_valid=1, the D beat is consumed per REQ-012 directly).
REQ-011 WAIT: a_valid and a_channel held unchanged, d_ready=1; remains until d_valid=1 or timeout.
REQ-012 On a posedge with d_valid=1 in ISSUE/WAIT: capture d_channel, drop a_valid, a_ready, d_ready the next cycle, go to RESP.
REQ-013 RESP: rsp_valid=1 for exactly one cycle; rsp_rdata = captured data[31:0] for Get, 0 for Put; then IDLE.
REQ-014 rsp_error SHALL be 1 if d_error=1 at capture, or D opcode mismatches (expected 1 for Get, 0 for Put), or D source != 0.
REQ-015 An 8-bit timeout counter SHALL clear on entering ISSUE and increment each cycle in ISSUE/WAIT; reaching TIMEOUT -> drop a_valid, go RESP with rsp_error=1, rsp_rdata=0.
REQ-016 d_valid arriving in IDLE or RESP SHALL be ignored.
REQ-017 a_channel SHALL never change while a_valid=1.
REQ-018 Minimum request-to-rsp_valid latency SHALL be 3 cycles (push, ISSUE, RESP), plus slave delay.
REQ-019 One transaction SHALL be outstanding at a time.

Reset
REQ-020 On reset assertion, regardless of clock: state=IDLE, FIFO empty, counter 0, a_channel=0, a_valid=0, a_ready=0, d_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0; req_ready=1 after reset release.
REQ-021 Reset mid-transaction SHALL abandon it without emitting rsp_valid.

Verification
REQ-022 Put addr 0x005 data 0xDEADBEEF, then Get addr 0x005 -> first rsp_error=0, rsp_rdata=0; second rsp_rdata=0xDEADBEEF, rsp_error=0.
REQ-023 Three back-to-back req_valid cycles -> third sees req_ready=0 until first pops; all three responses in order.
REQ-024 Slave that delays d_valid 4 cycles with backpressureslave=1 -> a_channel stable for every cycle, single rsp_valid pulse.
REQ-025 Get answered with D opcode 0 or d_error=1 -> rsp_error=1.
REQ-026 No d_valid for TIMEOUT=64 cycles -> rsp_valid with rsp_error=1 at cycle 64, a_valid=0, state IDLE.
REQ-027 Reset asserted in WAIT -> all outputs zero immediately, no rsp_valid after release.
